multi_digit_entry: RTL and testbench
====================================

MULTI_DIGIT_ENTRY -- requirements
Module: multi_digit_entry

Interface
REQ-001 Parameter NDIGITS, default 4: number of BCD digits held; legal range 2..8.
REQ-002 Parameter BKSP_CODE, default 4'hA: keycode that deletes the last digit.
REQ-003 Parameter CLEAR_CODE, default 4'hB: keycode that discards the entry.
REQ-004 Parameter ENTER_CODE, default 4'hC: keycode that commits the entry.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 nrst  input  1  reset; asynchronous, active-low.
REQ-007 keystrobe  input  1  one-cycle key-press pulse; each high cycle is one press.
REQ-008 keycode  input  4  key identifier, sampled only when keystrobe=1.
REQ-009 isdig  output  1  registered one-cycle pulse: the accepted press was a digit 0-9.
REQ-010 digitCode  output  4  registered digit of the last press; 0 when isdig=0.
REQ-011 digits  output  4*NDIGITS  entry buffer, BCD; most recent digit in bits [3:0].
REQ-012 count  output  $clog2(NDIGITS+1)  number of digits in the buffer.
REQ-013 full  output  1  count==NDIGITS.
REQ-014 empty  output  1  count==0.
REQ-015 value  output  4*NDIGITS  last committed entry; holds until the next commit.
REQ-016 valid  output  1  one-cycle pulse on the cycle value updates.
REQ-017 err  output  1  one-cycle pulse on a rejected press.

Function
REQ-018 All outputs SHALL be registered; the response to a press at rising edge N SHALL be visible after edge N.
REQ-019 States: EMPTY (count=0), PARTIAL (0<count<NDIGITS), FULL (count=NDIGITS); full and empty SHALL decode directly from the state.
REQ-020 Digit press (keycode 0-9) in EMPTY/PARTIAL: digits <= {digits[4*NDIGITS-5:0], keycode}, count+1, isdig=1, digitCode=keycode; EMPTY->PARTIAL, or to FULL when count reaches NDIGITS.
REQ-021 Digit press in FULL: buffer and count unchanged, err=1, isdig=1, digitCode=keycode.
REQ-022 BKSP in PARTIAL/FULL: digits <= {4'h0, digits[4*NDIGITS-1:4]}, count-1; FULL->PARTIAL, PARTIAL->EMPTY when count reaches 0.
REQ-023 BKSP in EMPTY: no change, err=1.
REQ-024 CLEAR in any state: digits=0, count=0, ->EMPTY, no err, value unchanged.
REQ-025 ENTER in PARTIAL/FULL: value <= digits, valid=1, digits=0, count=0, ->EMPTY, in one cycle.
REQ-026 ENTER in EMPTY: value unchanged, valid=0, err=1.
REQ-027 Keycodes 4'hA-4'hF that match no parameter SHALL be ignored without err; isdig=0.
REQ-028 When keystrobe=0, isdig, digitCode, valid and err SHALL be 0 on the next cycle; all other state SHALL hold.
REQ-029 Back-to-back presses on consecutive cycles SHALL each be processed in full; no press SHALL be dropped.
REQ-030 Parameter codes that collide with each other or with 0-9 SHALL be rejected by an elaboration-time check.

Reset
REQ-031 On nrst=0, the block SHALL immediately set digits=0, count=0, value=0, isdig=0, digitCode=0, valid=0 and err=0, and enter EMPTY, with empty=1 and full=0.
REQ-032 Reset asserted mid-entry SHALL discard the partial entry, and the first press after release SHALL be processed normally.

Verification
REQ-033 Reset, then strobe codes 9 and 1 on consecutive cycles -> isdig pulses with digitCode 9 then 1; digits[7:0]=8'h91, count=2.
REQ-034 NDIGITS=4: press 1,2,3,4 then 5 -> after four presses full=1 and digits=16'h1234; the fifth press gives err=1 with digits unchanged.
REQ-035 Entry 1,2,3, then BKSP, then ENTER -> digits=16'h0012 after BKSP; on ENTER valid=1, value=16'h0012 and empty=1.
REQ-036 Reset, then BKSP and ENTER -> err pulses on each press; value stays 0 and valid stays 0.
REQ-037 Entry 7,8, then CLEAR, then keycode 4'hF, then keystrobe=0 with keycode=3 -> empty=1; no err and no isdig on the last two cycles.
REQ-038 nrst pulsed low between clock edges with count=3 -> outputs 0 immediately, without waiting for a clock edge; the next digit 6 gives digits=16'h0006 and count=1.

Source files
------------

// File: rtl/multi_digit_entry.sv
// Multi-digit BCD keypad entry buffer.
// Collects digit key presses into a shift buffer (newest digit in the low
// nibble). Backspace drops the newest digit, clear discards the entry, and
// enter commits the buffer to 'value' with a one-cycle 'valid' pulse.
// Rejected presses produce a one-cycle 'err' pulse. All outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------
// S_EMPTY   | no digits held (count == 0)
// S_PARTIAL | some digits held (0 < count < NDIGITS)
// S_FULL    | buffer full (count == NDIGITS), digits rejected
module multi_digit_entry #(
   parameter int       NDIGITS    = 4,
   parameter logic [3:0] BKSP_CODE  = 4'hA,
   parameter logic [3:0] CLEAR_CODE = 4'hB,
   parameter logic [3:0] ENTER_CODE = 4'hC
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               keystrobe,
   input  logic [3:0]                         keycode,
   output logic                               isdig,
   output logic [3:0]                         digitCode,
   output logic [4*NDIGITS-1:0]               digits,
   output logic [$clog2(NDIGITS+1)-1:0]       count,
   output logic                               full,
   output logic                               empty,
   output logic [4*NDIGITS-1:0]               value,
   output logic                               valid,
   output logic                               err
);

   localparam int CW = $clog2(NDIGITS + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);

   // Parameter sanity: digit count in range, control codes distinct and outside 0-9.
   if (NDIGITS < 2 || NDIGITS > 8) begin : g_bad_ndigits
      $error("multi_digit_entry: NDIGITS must be in 2..8");
   end
   if (BKSP_CODE <= 4'd9 || CLEAR_CODE <= 4'd9 || ENTER_CODE <= 4'd9) begin : g_bad_code_digit
      $error("multi_digit_entry: control keycodes must not overlap digits 0-9");
   end
   if (BKSP_CODE == CLEAR_CODE || BKSP_CODE == ENTER_CODE || CLEAR_CODE == ENTER_CODE) begin : g_bad_code_dup
      $error("multi_digit_entry: control keycodes must be distinct");
   end

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_PARTIAL = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   state_t state;

   logic key_is_digit;
   assign key_is_digit = (keycode <= 4'd9);

   // Occupancy flags are pure state decodes so they track the FSM exactly.
   assign full  = (state == S_FULL);
   assign empty = (state == S_EMPTY);

   // Key-press FSM: buffer, count, committed value and per-press pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_EMPTY;
         digits    <= '0;
         count     <= '0;
         value     <= '0;
         isdig     <= 1'b0;
         digitCode <= 4'h0;
         valid     <= 1'b0;
         err       <= 1'b0;
      end else begin
         isdig     <= 1'b0;
         digitCode <= 4'h0;
         valid     <= 1'b0;
         err       <= 1'b0;

         if (keystrobe) begin
            if (key_is_digit) begin
               // A digit is reported even when the full buffer rejects it.
               isdig     <= 1'b1;
               digitCode <= keycode;
               if (state == S_FULL) begin
                  err <= 1'b1;
               end else begin
                  digits <= {digits[4*NDIGITS-5:0], keycode};
                  count  <= count + CNT_ONE;
                  state  <= (count == CNT_LAST) ? S_FULL : S_PARTIAL;
               end
            end else if (keycode == BKSP_CODE) begin
               if (state == S_EMPTY) begin
                  err <= 1'b1;
               end else begin
                  digits <= {4'h0, digits[4*NDIGITS-1:4]};
                  count  <= count - CNT_ONE;
                  state  <= (count == CNT_ONE) ? S_EMPTY : S_PARTIAL;
               end
            end else if (keycode == CLEAR_CODE) begin
               digits <= '0;
               count  <= '0;
               state  <= S_EMPTY;
            end else if (keycode == ENTER_CODE) begin
               if (state == S_EMPTY) begin
                  err <= 1'b1;
               end else begin
                  value  <= digits;
                  valid  <= 1'b1;
                  digits <= '0;
                  count  <= '0;
                  state  <= S_EMPTY;
               end
            end
            // Unassigned control codes fall through silently.
         end
      end
   end

endmodule

// File: tb/tb_multi_digit_entry.sv
// Scoreboard bench for multi_digit_entry: the driver updates a queue-based
// model of the entry and pushes the expected outputs; a monitor pops and
// compares one entry after every rising edge.
module tb_multi_digit_entry;

   localparam int N = 4;
   localparam int CW = $clog2(N + 1);
   localparam logic [3:0] BK = 4'hA;
   localparam logic [3:0] CL = 4'hB;
   localparam logic [3:0] EN = 4'hC;

   logic            tb_clk;
   logic            nrst;
   logic            keystrobe;
   logic [3:0]      keycode;
   logic            isdig;
   logic [3:0]      digit_code;
   logic [4*N-1:0]  digits;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic [4*N-1:0]  value;
   logic            valid;
   logic            err;

   multi_digit_entry #(
      .NDIGITS(N), .BKSP_CODE(BK), .CLEAR_CODE(CL), .ENTER_CODE(EN)
   ) dut (
      .clk(tb_clk), .nrst(nrst), .keystrobe(keystrobe), .keycode(keycode),
      .isdig(isdig), .digitCode(digit_code), .digits(digits), .count(count),
      .full(full), .empty(empty), .value(value), .valid(valid), .err(err)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   typedef struct packed {
      logic           isdig;
      logic [3:0]     dc;
      logic [4*N-1:0] digits;
      logic [CW-1:0]  count;
      logic           full;
      logic           empty;
      logic [4*N-1:0] value;
      logic           valid;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: list of entered digits (oldest first) and committed value.
   int             m_q[$];
   logic [4*N-1:0] m_value;

   function automatic logic [4*N-1:0] pack_entry();
      logic [4*N-1:0] d = '0;
      for (int i = 0; i < m_q.size(); i++)
         d = d | ((4*N)'(m_q[m_q.size()-1-i]) << (4*i));
      return d;
   endfunction

   function automatic exp_t model_step(input logic ks, input logic [3:0] kc);
      exp_t e = '0;
      if (ks) begin
         if (kc <= 4'd9) begin
            e.isdig = 1'b1;
            e.dc    = kc;
            if (m_q.size() == N) e.err = 1'b1;
            else m_q.push_back(int'(kc));
         end else if (kc == BK) begin
            if (m_q.size() == 0) e.err = 1'b1;
            else void'(m_q.pop_back());
         end else if (kc == CL) begin
            m_q.delete();
         end else if (kc == EN) begin
            if (m_q.size() == 0) e.err = 1'b1;
            else begin
               m_value = pack_entry();
               e.valid = 1'b1;
               m_q.delete();
            end
         end
      end
      e.digits = pack_entry();
      e.count  = CW'(m_q.size());
      e.full   = (m_q.size() == N);
      e.empty  = (m_q.size() == 0);
      e.value  = m_value;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one expected record per clock edge after the stimulus issued it.
   initial begin
      exp_t e;
      forever begin
         @(posedge tb_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("isdig",     32'(isdig),      32'(e.isdig));
            chk("digitCode", 32'(digit_code), 32'(e.dc));
            chk("digits",    32'(digits),     32'(e.digits));
            chk("count",     32'(count),      32'(e.count));
            chk("full",      32'(full),       32'(e.full));
            chk("empty",     32'(empty),      32'(e.empty));
            chk("value",     32'(value),      32'(e.value));
            chk("valid",     32'(valid),      32'(e.valid));
            chk("err",       32'(err),        32'(e.err));
         end
      end
   end

   task automatic press(input logic ks, input logic [3:0] kc);
      @(negedge tb_clk);
      keystrobe = ks;
      keycode   = kc;
      exp_q.push_back(model_step(ks, kc));
   endtask

   // Pulse reset between edges and confirm outputs clear without a clock edge.
   task automatic mid_reset();
      @(negedge tb_clk);
      keystrobe = 1'b0;
      keycode   = 4'h0;
      #2 nrst = 1'b0;
      #1;
      chk("rst_digits", 32'(digits),     32'h0);
      chk("rst_count",  32'(count),      32'h0);
      chk("rst_value",  32'(value),      32'h0);
      chk("rst_isdig",  32'(isdig),      32'h0);
      chk("rst_dc",     32'(digit_code), 32'h0);
      chk("rst_valid",  32'(valid),      32'h0);
      chk("rst_err",    32'(err),        32'h0);
      chk("rst_empty",  32'(empty),      32'h1);
      chk("rst_full",   32'(full),       32'h0);
      #1 nrst = 1'b1;
      m_q.delete();
      m_value = '0;
      exp_q.push_back(model_step(1'b0, 4'h0));
   endtask

   initial begin
      logic [3:0] kc;
      nrst      = 1'b0;
      keystrobe = 1'b0;
      keycode   = 4'h0;
      m_value   = '0;
      #2;
      chk("init_empty", 32'(empty), 32'h1);
      chk("init_count", 32'(count), 32'h0);
      @(negedge tb_clk);
      nrst = 1'b1;

      // Two consecutive digits.
      press(1, 4'd9); press(1, 4'd1);
      press(1, CL);
      // Fill to capacity then overflow.
      press(1, 4'd1); press(1, 4'd2); press(1, 4'd3); press(1, 4'd4); press(1, 4'd5);
      press(1, CL);
      // Backspace then commit.
      press(1, 4'd1); press(1, 4'd2); press(1, 4'd3); press(1, BK); press(1, EN);
      press(0, 4'h0);
      // Rejected backspace/enter on an empty buffer after reset.
      mid_reset();
      press(1, BK); press(1, EN);
      // Clear, unassigned code, idle with digit on the bus.
      press(1, 4'd7); press(1, 4'd8); press(1, CL); press(1, 4'hF); press(0, 4'd3);
      // Commit something, then reset mid-entry with three digits held.
      press(1, 4'd5); press(1, EN);
      press(1, 4'd4); press(1, 4'd2); press(1, 4'd8);
      mid_reset();
      press(1, 4'd6);
      press(0, 4'h0);

      // Randomised key traffic with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            mid_reset();
         end else begin
            case ($urandom_range(0, 9))
               0:       kc = BK;
               1:       kc = EN;
               2:       kc = 4'($urandom_range(10, 15));
               default: kc = 4'($urandom_range(0, 9));
            endcase
            press(($urandom_range(0, 3) != 0), kc);
         end
      end

      press(0, 4'h0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge tb_clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
